// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, predicts the next fetch address with a
// small direct-mapped BTB (2-bit counters), resolves branch/jal/jalr in EX
// and redirects fetch on mispredict.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall_if        hold the fetch PC (load-use hazard)
//   ex_valid        EX holds a valid instruction
//   pc_sel_ex       00 seq, 01 branch, 10 jal, 11 jalr
//   alu_branch      branch condition true
//   pc_ex           PC of the EX instruction
//   sext_ex         absolute target (branch/jal) or offset (jalr)
//   rD1_ex          rs1 value for jalr
//   pred_taken_ex   prediction carried down with the EX instruction
//   pred_target_ex  predicted target carried down with the EX instruction
//   pc_if           current fetch PC (also the instruction-memory address)
//   pred_taken_if   BTB predicts taken for pc_if
//   pred_target_if  BTB target for pc_if (0 on a miss)
//   flush_id        squash IF/ID this cycle
//   flush_ex        squash ID/EX this cycle
//   mispredict_cnt  saturating count of redirects since reset
//
// Handshake: there is no valid/ready pairing here; ex_valid qualifies the EX
// inputs for the current cycle and flush_* answer it combinationally.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        ex_valid,
    input  logic [1:0]  pc_sel_ex,
    input  logic        alu_branch,
    input  logic [31:0] pc_ex,
    input  logic [31:0] sext_ex,
    input  logic [31:0] rD1_ex,
    input  logic        pred_taken_ex,
    input  logic [31:0] pred_target_ex,
    output logic [31:0] pc_if,
    output logic        pred_taken_if,
    output logic [31:0] pred_target_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [31:0] mispredict_cnt
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      mispredict_cnt_q, mispredict_cnt_d;
    logic             btb_valid_q  [BTB_N];
    logic             btb_valid_d  [BTB_N];
    logic [TAG_W-1:0] btb_tag_q    [BTB_N];
    logic [TAG_W-1:0] btb_tag_d    [BTB_N];
    logic [31:0]      btb_target_q [BTB_N];
    logic [31:0]      btb_target_d [BTB_N];
    logic [1:0]       btb_ctr_q    [BTB_N];
    logic [1:0]       btb_ctr_d    [BTB_N];

    // Fetch-side lookup reads the registered contents, so a same-cycle
    // update of the same entry is only visible from the next cycle on.
    logic [BTB_IDX_W-1:0] if_idx;
    logic [TAG_W-1:0]     if_tag;
    logic                 if_hit;

    assign if_idx         = pc_q[BTB_IDX_W+1:2];
    assign if_tag         = pc_q[31:BTB_IDX_W+2];
    assign if_hit         = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign pred_taken_if  = if_hit && btb_ctr_q[if_idx][1];
    assign pred_target_if = if_hit ? btb_target_q[if_idx] : 32'h0;

    // EX resolution
    logic        actual_taken;
    logic [31:0] actual_target;
    logic [31:0] jalr_sum;
    logic [31:0] fallthrough;
    logic        mispredict;
    logic        unused_bits;

    assign jalr_sum    = rD1_ex + sext_ex;
    assign fallthrough = pc_ex + 32'd4;
    assign unused_bits = jalr_sum[0];

    always_comb begin
        actual_taken  = 1'b0;
        actual_target = 32'h0;
        if (ex_valid) begin
            unique case (pc_sel_ex)
                2'b01: begin
                    actual_taken  = alu_branch;
                    actual_target = sext_ex;
                end
                2'b10: begin
                    actual_taken  = 1'b1;
                    actual_target = sext_ex;
                end
                2'b11: begin
                    actual_taken  = 1'b1;
                    actual_target = {jalr_sum[31:1], 1'b0};
                end
                default: ;
            endcase
        end
    end

    // Gated by rst so the flushes read 0 while reset is held.
    assign mispredict = !rst && ex_valid &&
                        ((actual_taken != pred_taken_ex) ||
                         (actual_taken && (actual_target != pred_target_ex)));
    assign flush_id       = mispredict;
    assign flush_ex       = mispredict;
    assign pc_if          = pc_q;
    assign mispredict_cnt = mispredict_cnt_q;

    // EX-side BTB entry for the update
    logic [BTB_IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_hit;

    assign ex_idx = pc_ex[BTB_IDX_W+1:2];
    assign ex_tag = pc_ex[31:BTB_IDX_W+2];
    assign ex_hit = btb_valid_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);

    always_comb begin
        pc_d             = pc_q;
        mispredict_cnt_d = mispredict_cnt_q;
        btb_valid_d      = btb_valid_q;
        btb_tag_d        = btb_tag_q;
        btb_target_d     = btb_target_q;
        btb_ctr_d        = btb_ctr_q;

        // Redirect beats stall: the squashed instruction must not be refetched.
        if (mispredict) begin
            pc_d = actual_taken ? actual_target : fallthrough;
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (pred_taken_if) begin
            pc_d = pred_target_if;
        end else begin
            pc_d = pc_q + 32'd4;
        end

        if (mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end

        // Training ignores stall_if: the EX instruction resolves either way.
        if (ex_valid && (pc_sel_ex != 2'b00)) begin
            if (pc_sel_ex == 2'b01) begin
                if (ex_hit) begin
                    if (actual_taken) begin
                        if (btb_ctr_q[ex_idx] != 2'b11) begin
                            btb_ctr_d[ex_idx] = btb_ctr_q[ex_idx] + 2'b01;
                        end
                        btb_target_d[ex_idx] = actual_target;
                    end else if (btb_ctr_q[ex_idx] != 2'b00) begin
                        btb_ctr_d[ex_idx] = btb_ctr_q[ex_idx] - 2'b01;
                    end
                end else if (actual_taken) begin
                    btb_valid_d[ex_idx]  = 1'b1;
                    btb_tag_d[ex_idx]    = ex_tag;
                    btb_target_d[ex_idx] = actual_target;
                    btb_ctr_d[ex_idx]    = 2'b10;
                end
            end else begin
                btb_valid_d[ex_idx]  = 1'b1;
                btb_tag_d[ex_idx]    = ex_tag;
                btb_target_d[ex_idx] = actual_target;
                btb_ctr_d[ex_idx]    = 2'b11;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q             <= RESET_PC;
            mispredict_cnt_q <= 32'h0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= 32'h0;
                btb_ctr_q[i]    <= 2'b00;
            end
        end else begin
            pc_q             <= pc_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i]  <= btb_valid_d[i];
                btb_tag_q[i]    <= btb_tag_d[i];
                btb_target_q[i] <= btb_target_d[i];
                btb_ctr_q[i]    <= btb_ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed steps from the test plan followed by
// a randomized phase, all checked against a behavioural model of the fetch
// PC, redirect counter and BTB contents.
module tb_pc_sequencer;

    localparam int IDXW = 3;
    localparam int N    = 1 << IDXW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if;
    logic        ex_valid;
    logic [1:0]  pc_sel_ex;
    logic        alu_branch;
    logic [31:0] pc_ex;
    logic [31:0] sext_ex;
    logic [31:0] rD1_ex;
    logic        pred_taken_ex;
    logic [31:0] pred_target_ex;
    logic [31:0] pc_if;
    logic        pred_taken_if;
    logic [31:0] pred_target_if;
    logic        flush_id;
    logic        flush_ex;
    logic [31:0] mispredict_cnt;

    pc_sequencer #(.RESET_PC(32'h0), .BTB_IDX_W(IDXW)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .ex_valid(ex_valid),
        .pc_sel_ex(pc_sel_ex), .alu_branch(alu_branch), .pc_ex(pc_ex),
        .sext_ex(sext_ex), .rD1_ex(rD1_ex), .pred_taken_ex(pred_taken_ex),
        .pred_target_ex(pred_target_ex), .pc_if(pc_if),
        .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];

    // Model outputs for the current inputs
    bit          e_ptaken;
    logic [31:0] e_ptarget;
    bit          e_taken;
    logic [31:0] e_target;
    bit          e_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_cnt = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'h0;
            m_target[i] = 32'h0;
            m_ctr[i]    = 0;
        end
    endtask

    task automatic model_eval();
        int unsigned idx;
        logic [31:0] tag;
        logic [31:0] sum;
        idx = (m_pc / 4) % N;
        tag = m_pc / (4 * N);
        e_ptaken  = m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
        e_ptarget = (m_valid[idx] && (m_tag[idx] == tag)) ? m_target[idx] : 32'h0;
        e_taken  = 1'b0;
        e_target = 32'h0;
        if (ex_valid) begin
            case (pc_sel_ex)
                2'd1: begin e_taken = alu_branch; e_target = sext_ex; end
                2'd2: begin e_taken = 1'b1; e_target = sext_ex; end
                2'd3: begin
                    sum      = rD1_ex + sext_ex;
                    e_taken  = 1'b1;
                    e_target = sum - (sum % 2);
                end
                default: ;
            endcase
        end
        e_mis = ex_valid && ((e_taken != pred_taken_ex) ||
                             (e_taken && (e_target != pred_target_ex)));
    endtask

    task automatic model_update();
        int unsigned idx;
        logic [31:0] tag;
        bit          hit;
        logic [31:0] fall;
        fall = pc_ex + 32'd4;
        if (ex_valid && (pc_sel_ex != 2'd0)) begin
            idx = (pc_ex / 4) % N;
            tag = pc_ex / (4 * N);
            hit = m_valid[idx] && (m_tag[idx] == tag);
            if (pc_sel_ex != 2'd1 || (!hit && e_taken)) begin
                m_valid[idx]  = 1'b1;
                m_tag[idx]    = tag;
                m_target[idx] = e_target;
                m_ctr[idx]    = (pc_sel_ex == 2'd1) ? 2 : 3;
            end else if (hit && e_taken) begin
                m_ctr[idx]    = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
                m_target[idx] = e_target;
            end else if (hit) begin
                m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
            end
        end
        if (e_mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (e_mis)             m_pc = e_taken ? e_target : fall;
        else if (stall_if)     m_pc = m_pc;
        else if (e_ptaken)     m_pc = e_ptarget;
        else                   m_pc = m_pc + 32'd4;
    endtask

    // One clock: check all outputs at the falling edge, then advance the model.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("pc_if", pc_if, m_pc);
        check("pred_taken_if", {31'b0, pred_taken_if}, {31'b0, e_ptaken});
        check("pred_target_if", pred_target_if, e_ptarget);
        check("flush_id", {31'b0, flush_id}, {31'b0, e_mis});
        check("flush_ex", {31'b0, flush_ex}, {31'b0, e_mis});
        check("mispredict_cnt", mispredict_cnt, m_cnt);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive_ex(input logic [1:0] sel, input logic br,
                            input logic [31:0] pcx, input logic [31:0] sx,
                            input logic [31:0] r1, input logic pt,
                            input logic [31:0] ptg);
        ex_valid       = 1'b1;
        pc_sel_ex      = sel;
        alu_branch     = br;
        pc_ex          = pcx;
        sext_ex        = sx;
        rD1_ex         = r1;
        pred_taken_ex  = pt;
        pred_target_ex = ptg;
    endtask

    task automatic idle();
        ex_valid       = 1'b0;
        pc_sel_ex      = 2'd0;
        alu_branch     = 1'b0;
        pc_ex          = 32'h0;
        sext_ex        = 32'h0;
        rD1_ex         = 32'h0;
        pred_taken_ex  = 1'b0;
        pred_target_ex = 32'h0;
    endtask

    initial begin
        stall_if = 1'b0;
        idle();
        model_reset();

        // Asynchronous reset, no clock edge yet
        #1 rst = 1'b1;
        #1;
        check("reset_pc", pc_if, 32'h0);
        check("reset_cnt", mispredict_cnt, 32'h0);
        check("reset_pred", {31'b0, pred_taken_if}, 32'h0);
        check("reset_ptarget", pred_target_if, 32'h0);
        check("reset_flush", {30'b0, flush_id, flush_ex}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Sequential fetch then a two-cycle stall at 0x8
        repeat (2) step();
        check("seq_pc8", pc_if, 32'h8);
        stall_if = 1'b1;
        repeat (2) step();
        check("stall_hold", pc_if, 32'h8);
        stall_if = 1'b0;
        step();
        check("after_stall", pc_if, 32'hC);

        // jal mispredict at 0x10 -> 0x40
        drive_ex(2'b10, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0, 32'h0);
        #1 check("jal_flush", {31'b0, flush_id}, 32'h1);
        step();
        idle();
        check("jal_pc", pc_if, 32'h40);
        check("jal_cnt", mispredict_cnt, 32'h1);
        drive_ex(2'b10, 1'b0, 32'h4C, 32'h10, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        #1;
        check("btb_hit_taken", {31'b0, pred_taken_if}, 32'h1);
        check("btb_hit_target", pred_target_if, 32'h40);
        step();
        check("pred_follow", pc_if, 32'h40);

        // Branch at 0x20: taken then not taken
        drive_ex(2'b01, 1'b1, 32'h20, 32'h8, 32'h0, 1'b0, 32'h0);
        step();
        check("br_taken_pc", pc_if, 32'h8);
        drive_ex(2'b01, 1'b0, 32'h20, 32'h8, 32'h0, 1'b1, 32'h8);
        #1 check("br_nt_flush", {31'b0, flush_ex}, 32'h1);
        step();
        check("br_nt_pc", pc_if, 32'h24);
        drive_ex(2'b10, 1'b0, 32'h4C, 32'h20, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        #1;
        check("br_weak_pred", {31'b0, pred_taken_if}, 32'h0);
        check("br_weak_target", pred_target_if, 32'h8);
        step();

        // jalr redirect overrides stall
        drive_ex(2'b11, 1'b0, 32'h34, 32'h4, 32'h103, 1'b1, 32'h100);
        stall_if = 1'b1;
        #1 check("jalr_flush", {30'b0, flush_id, flush_ex}, 32'h3);
        step();
        stall_if = 1'b0;
        idle();
        check("jalr_pc", pc_if, 32'h106);

        // PC wrap and fallthrough wrap
        drive_ex(2'b10, 1'b0, 32'h4C, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        check("wrap_top", pc_if, 32'hFFFF_FFFC);
        step();
        check("wrap_seq", pc_if, 32'h0);
        drive_ex(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1, 32'h8);
        step();
        idle();
        check("wrap_fall", pc_if, 32'h0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            ex_valid   = ($urandom_range(0, 9) < 7);
            pc_sel_ex  = 2'($urandom_range(0, 3));
            alu_branch = 1'($urandom_range(0, 1));
            pc_ex      = $urandom_range(0, 31) * 4;
            sext_ex    = $urandom_range(0, 31) * 4;
            rD1_ex     = $urandom_range(0, 255);
            stall_if   = ($urandom_range(0, 4) == 0);
            model_eval();
            if ($urandom_range(0, 1) == 1) begin
                pred_taken_ex  = e_taken;
                pred_target_ex = e_taken ? e_target : 32'h0;
            end else begin
                pred_taken_ex  = 1'($urandom_range(0, 1));
                pred_target_ex = $urandom_range(0, 31) * 4;
            end
            step();
        end
        stall_if = 1'b0;

        // Reset between edges with a redirect pending
        drive_ex(2'b10, 1'b0, 32'h10, 32'h40, 32'h0, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_pc", pc_if, 32'h0);
        check("mid_rst_cnt", mispredict_cnt, 32'h0);
        check("mid_rst_flush", {30'b0, flush_id, flush_ex}, 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_hold", pc_if, 32'h0);
        idle();
        rst = 1'b0;
        model_reset();
        drive_ex(2'b10, 1'b0, 32'h4C, 32'h10, 32'h0, 1'b0, 32'h0);
        step();
        idle();
        #1;
        check("post_rst_pc", pc_if, 32'h10);
        check("post_rst_pred", {31'b0, pred_taken_if}, 32'h0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
